// File: rtl/diff_freq_serial_in_if.sv
// Diff-freq serial decoder bus: encoded line in, decoded frame and status pulses out.
interface diff_freq_serial_in_if #(
    parameter int unsigned DATA_BIT = 8
);
    logic                serial_in_i;
    logic [DATA_BIT-1:0] data_o;
    logic                done_tick_o;
    logic                bit_tick_o;
    logic                err_tick_o;
    logic                busy_o;

    // Line driver / frame consumer side
    modport master (
        output serial_in_i,
        input  data_o,
        input  done_tick_o,
        input  bit_tick_o,
        input  err_tick_o,
        input  busy_o
    );

    // Decoder side
    modport slave (
        input  serial_in_i,
        output data_o,
        output done_tick_o,
        output bit_tick_o,
        output err_tick_o,
        output busy_o
    );
endinterface

// File: rtl/diff_freq_serial_in.sv
// Diff-freq serial decoder: the high width of each bit cell selects '1' (short) or '0' (long).
// Frames are DATA_BIT bits, LSB first; glitches, over-long highs and long low gaps abort a frame.
module diff_freq_serial_in #(
    parameter int unsigned DATA_BIT     = 8,
    parameter int unsigned FAST_PERIOD  = 10,
    parameter int unsigned SLOW_PERIOD  = 20,
    parameter int unsigned GLITCH_MIN   = 2,
    parameter int unsigned IDLE_TIMEOUT = 2 * SLOW_PERIOD
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    diff_freq_serial_in_if.slave bus
);

    localparam int unsigned THRESH = (FAST_PERIOD + SLOW_PERIOD) / 4;
    localparam int unsigned W_W    = $clog2(SLOW_PERIOD + 2);
    localparam int unsigned L_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned B_W    = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic                sync_ff1, sync_ff2, prev_q;
    logic                rise_c, fall_c;
    logic [L_W-1:0]      low_next_c;

    state_t              state_q, state_d;
    logic [W_W-1:0]      w_cnt_q, w_cnt_d;
    logic [L_W-1:0]      low_cnt_q, low_cnt_d;
    logic [B_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BIT-1:0] shreg_q, shreg_d;
    logic                bit_pend_q, bit_pend_d;
    logic                done_pend_q, done_pend_d;
    logic                err_pend_q, err_pend_d;

    logic [DATA_BIT-1:0] data_q;
    logic                done_tick_q, bit_tick_q, err_tick_q, busy_q;

    // Two-flop synchronizer plus previous-value stage for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync_ff1 <= bus.serial_in_i;
            sync_ff2 <= sync_ff1;
            prev_q   <= sync_ff2;
        end
    end

    assign rise_c     = sync_ff2 & ~prev_q;
    assign fall_c     = ~sync_ff2 & prev_q;
    assign low_next_c = low_cnt_q + L_W'(1);

    // FSM state, counters, shift register and pending pulse registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            w_cnt_q     <= '0;
            low_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            bit_pend_q  <= 1'b0;
            done_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_cnt_q     <= w_cnt_d;
            low_cnt_q   <= low_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            bit_pend_q  <= bit_pend_d;
            done_pend_q <= done_pend_d;
            err_pend_q  <= err_pend_d;
        end
    end

    // Next-state: measure high width, decode on fall, police low gaps
    always_comb begin
        state_d     = state_q;
        w_cnt_d     = w_cnt_q;
        low_cnt_d   = low_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        bit_pend_d  = 1'b0;
        done_pend_d = 1'b0;
        err_pend_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d   = HIGH;
                    w_cnt_d   = W_W'(1);
                    bit_cnt_d = '0;
                end
            end

            HIGH: begin
                // Over-long high aborts without waiting for the fall
                if (w_cnt_q > W_W'(SLOW_PERIOD)) begin
                    err_pend_d = 1'b1;
                    state_d    = IDLE;
                end else if (fall_c) begin
                    if (w_cnt_q < W_W'(GLITCH_MIN)) begin
                        err_pend_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        shreg_d[bit_cnt_q] = (w_cnt_q < W_W'(THRESH));
                        bit_pend_d         = 1'b1;
                        if (bit_cnt_q == B_W'(DATA_BIT - 1)) begin
                            done_pend_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d   = LOW;
                            low_cnt_d = '0;
                            bit_cnt_d = bit_cnt_q + B_W'(1);
                        end
                    end
                end else begin
                    w_cnt_d = w_cnt_q + W_W'(1);
                end
            end

            LOW: begin
                // A rise on the timeout cycle wins and keeps the frame alive
                if (rise_c) begin
                    state_d = HIGH;
                    w_cnt_d = W_W'(1);
                end else if (low_next_c >= L_W'(IDLE_TIMEOUT)) begin
                    err_pend_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    low_cnt_d = low_next_c;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs; ticks trail acceptance by one cycle to give fixed latency
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q      <= '0;
            done_tick_q <= 1'b0;
            bit_tick_q  <= 1'b0;
            err_tick_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bit_tick_q  <= bit_pend_q;
            done_tick_q <= done_pend_q;
            err_tick_q  <= err_pend_q;
            busy_q      <= (state_d != IDLE);
            if (done_pend_q) begin
                data_q <= shreg_q;
            end
        end
    end

    assign bus.data_o      = data_q;
    assign bus.done_tick_o = done_tick_q;
    assign bus.bit_tick_o  = bit_tick_q;
    assign bus.err_tick_o  = err_tick_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Directed bench for diff_freq_serial_in with default timing (cells 10/20, highs 5/10).
module tb_diff_freq_serial_in;

    localparam int unsigned DATA_BIT = 8;

    logic clk_i = 1'b0;
    logic rst_i;

    int n_checks = 0;
    int n_errors = 0;
    int n_bit    = 0;
    int n_done   = 0;
    int n_err    = 0;
    int b_bit, b_done, b_err;
    logic [DATA_BIT-1:0] done_data [16];
    logic [3:0]          lat_seen;

    always #5 clk_i = ~clk_i;

    diff_freq_serial_in_if #(.DATA_BIT(DATA_BIT)) bus ();

    diff_freq_serial_in #(
        .DATA_BIT    (DATA_BIT),
        .FAST_PERIOD (10),
        .SLOW_PERIOD (20),
        .GLITCH_MIN  (2),
        .IDLE_TIMEOUT(40)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk_i) begin
        if (bus.bit_tick_o) n_bit++;
        if (bus.err_tick_o) n_err++;
        if (bus.done_tick_o) begin
            if (n_done < 16) done_data[n_done] = bus.data_o;
            n_done++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_bit  = n_bit;
        b_done = n_done;
        b_err  = n_err;
    endtask

    // Line high for h cycles, then low for l cycles; changes land 1ns after a rising edge
    task automatic pulse(input int h, input int l);
        repeat (h) begin @(posedge clk_i); #1 bus.serial_in_i = 1'b1; end
        repeat (l) begin @(posedge clk_i); #1 bus.serial_in_i = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1 bus.serial_in_i = 1'b0; end
    endtask

    // LSB first; bit gap_idx gets a low of gap_len, the last bit a low of last_low
    task automatic send_frame(input logic [7:0] v, input int gap_idx, input int gap_len,
                              input int last_low);
        int hi, lo;
        for (int i = 0; i < 8; i++) begin
            hi = v[i] ? 5 : 10;
            lo = (i == 7) ? last_low : ((i == gap_idx) ? gap_len : hi);
            pulse(hi, lo);
        end
    endtask

    initial begin
        bus.serial_in_i = 1'b0;
        rst_i           = 1'b1;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_data", 32'(bus.data_o), 32'h00);
        check_eq("rst_busy", 32'(bus.busy_o), 32'h0);
        check_eq("rst_ticks", {29'd0, bus.done_tick_o, bus.bit_tick_o, bus.err_tick_o}, 32'h0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        idle(5);

        // Frame 0xA5
        mark();
        send_frame(8'hA5, -1, 0, 10);
        idle(20);
        check_eq("a5_bits", n_bit - b_bit, 8);
        check_eq("a5_done", n_done - b_done, 1);
        check_eq("a5_err", n_err - b_err, 0);
        check_eq("a5_data", 32'(bus.data_o), 32'hA5);
        check_eq("a5_busy", 32'(bus.busy_o), 32'h0);

        // One-cycle glitch, then 0x3C
        mark();
        pulse(1, 10);
        idle(10);
        check_eq("glitch_err", n_err - b_err, 1);
        check_eq("glitch_bits", n_bit - b_bit, 0);
        check_eq("glitch_busy", 32'(bus.busy_o), 32'h0);
        mark();
        send_frame(8'h3C, -1, 0, 10);
        idle(20);
        check_eq("3c_data", 32'(bus.data_o), 32'h3C);
        check_eq("3c_done", n_done - b_done, 1);
        check_eq("3c_err", n_err - b_err, 0);

        // Three bits then a long low gap, then 0xFF
        mark();
        pulse(5, 5);
        pulse(10, 10);
        pulse(5, 5);
        idle(60);
        check_eq("tmo_err", n_err - b_err, 1);
        check_eq("tmo_bits", n_bit - b_bit, 3);
        check_eq("tmo_done", n_done - b_done, 0);
        check_eq("tmo_data", 32'(bus.data_o), 32'h3C);
        mark();
        send_frame(8'hFF, -1, 0, 10);
        idle(20);
        check_eq("ff_data", 32'(bus.data_o), 32'hFF);

        // Widths 6,7,20 then five '1' bits -> 1,0,0,1,1,1,1,1 = 0xF9
        mark();
        pulse(6, 5);
        pulse(7, 5);
        pulse(20, 5);
        repeat (4) pulse(5, 5);
        pulse(5, 10);
        idle(20);
        check_eq("w_data", 32'(bus.data_o), 32'hF9);
        check_eq("w_err", n_err - b_err, 0);

        // Width 21 aborts
        mark();
        pulse(21, 10);
        idle(20);
        check_eq("w21_err", n_err - b_err, 1);
        check_eq("w21_bits", n_bit - b_bit, 0);

        // Stuck-high line aborts while still high; the later fall must not restart decoding
        mark();
        repeat (30) begin @(posedge clk_i); #1 bus.serial_in_i = 1'b1; end
        @(negedge clk_i);
        check_eq("hi_err_early", n_err - b_err, 1);
        idle(60);
        check_eq("hi_err_once", n_err - b_err, 1);
        check_eq("hi_bits", n_bit - b_bit, 0);
        check_eq("hi_data", 32'(bus.data_o), 32'hF9);

        // Rise on the timeout cycle (40 low cycles) keeps the frame
        mark();
        send_frame(8'h55, 0, 40, 10);
        idle(20);
        check_eq("gap40_err", n_err - b_err, 0);
        check_eq("gap40_data", 32'(bus.data_o), 32'h55);

        // 41 low cycles times out; the rise that follows starts a fresh frame
        mark();
        pulse(5, 41);
        send_frame(8'h5A, -1, 0, 10);
        idle(20);
        check_eq("gap41_err", n_err - b_err, 1);
        check_eq("gap41_done", n_done - b_done, 1);
        check_eq("gap41_data", 32'(bus.data_o), 32'h5A);

        // Back-to-back 0x00 / 0xFF, done latency measured from the last input fall
        mark();
        send_frame(8'h00, -1, 0, 1);
        for (int i = 0; i < 7; i++) pulse(5, 5);
        repeat (5) begin @(posedge clk_i); #1 bus.serial_in_i = 1'b1; end
        @(posedge clk_i); #1 bus.serial_in_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            lat_seen[k] = bus.done_tick_o;
        end
        idle(20);
        check_eq("b2b_latency", 32'(lat_seen), 32'h8);
        check_eq("b2b_done", n_done - b_done, 2);
        check_eq("b2b_first", 32'(done_data[b_done]), 32'h00);
        check_eq("b2b_second", 32'(done_data[b_done + 1]), 32'hFF);
        check_eq("b2b_err", n_err - b_err, 0);

        // Reset after bit 4 of a frame, then 0x81
        mark();
        pulse(5, 5);
        repeat (3) pulse(10, 10);
        @(negedge clk_i);
        check_eq("mid_bits", n_bit - b_bit, 4);
        check_eq("mid_busy", 32'(bus.busy_o), 32'h1);
        @(posedge clk_i); #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("mid_rst_data", 32'(bus.data_o), 32'h00);
        check_eq("mid_rst_outs", {28'd0, bus.busy_o, bus.done_tick_o, bus.bit_tick_o, bus.err_tick_o}, 32'h0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        idle(60);
        check_eq("mid_err", n_err - b_err, 0);
        mark();
        send_frame(8'h81, -1, 0, 10);
        idle(20);
        check_eq("81_data", 32'(bus.data_o), 32'h81);
        check_eq("81_done", n_done - b_done, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
